bf16_fp32_mul: RTL and testbench



---
 rtl/bf16_pkg.sv | 36 +++
 rtl/bf16_classify.sv | 23 ++
 rtl/bf16_fp32_mul.sv | 92 +++++++++
 tb/tb_bf16_fp32_mul.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/bf16_pkg.sv
// Shared types and constants for the bf16 x bf16 -> fp32 multiplier.
package bf16_pkg;

    localparam int          BF16_EXP_BIAS = 127;
    localparam int          EXP_MAX       = 255;
    localparam logic [31:0] FP32_QNAN     = 32'h7FC00000;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] mant;
    } bf16_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORMAL,
        FP_INF,
        FP_NAN
    } fp_class_e;

    // Stage-1 register contents: everything stage 2 needs to pack a result.
    typedef struct packed {
        logic               sign;
        fp_class_e          cls_a;
        fp_class_e          cls_b;
        logic [15:0]        prod;
        logic signed [9:0]  exp;
    } s1_t;

endpackage

// File: rtl/bf16_classify.sv
// Operand classifier: bf16 in, class plus significand with hidden bit out.
// Subnormals (exp==0) are folded into FP_ZERO.
module bf16_classify
    import bf16_pkg::*;
(
    input  bf16_t      op,
    output fp_class_e  cls,
    output logic [7:0] sig
);

    // Decode exponent/mantissa into a class and the 1.m significand
    always_comb begin
        cls = FP_NORMAL;
        sig = {1'b1, op.mant};
        if (op.exp == 8'd0) begin
            cls = FP_ZERO;
            sig = 8'd0;
        end else if (op.exp == 8'(EXP_MAX)) begin
            cls = (op.mant == 7'd0) ? FP_INF : FP_NAN;
        end
    end

endmodule

// File: rtl/bf16_fp32_mul.sv
// Two-stage bf16 x bf16 multiplier producing an exact fp32 product.
// Stage 1 classifies operands and forms the 16-bit significand product and
// the biased exponent sum; stage 2 normalizes, resolves specials and packs.
module bf16_fp32_mul
    import bf16_pkg::*;
#(
    parameter int FLUSH_DENORM = 1
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    output logic [31:0] out
);

    localparam int STAGES = 2;

    // The datapath flushes subnormals; FLUSH_DENORM=1 is the only legal setting.
    generate
        if (FLUSH_DENORM != 1) begin : g_bad_flush
            $error("bf16_fp32_mul: FLUSH_DENORM must be 1");
        end
    endgenerate

    bf16_t            op_a, op_b;
    fp_class_e        cls_a, cls_b;
    logic [7:0]       sig_a, sig_b;
    s1_t              s1_d, s1_q;
    logic [STAGES:1]  vld_pipe;

    assign op_a = bf16_t'(a);
    assign op_b = bf16_t'(b);

    bf16_classify u_cls_a (.op(op_a), .cls(cls_a), .sig(sig_a));
    bf16_classify u_cls_b (.op(op_b), .cls(cls_b), .sig(sig_b));

    // Stage-1 next state: sign, classes, significand product, exponent sum
    always_comb begin
        s1_d       = '0;
        s1_d.sign  = op_a.sign ^ op_b.sign;
        s1_d.cls_a = cls_a;
        s1_d.cls_b = cls_b;
        s1_d.prod  = 16'(sig_a) * 16'(sig_b);
        s1_d.exp   = $signed({2'b00, op_a.exp}) + $signed({2'b00, op_b.exp})
                   - 10'sd127;
    end

    // Valid shift register; reset discards anything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
    end

    // Stage-1 register, loads only on an accepted operand pair
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           s1_q <= '0;
        else if (in_valid) s1_q <= s1_d;
    end

    logic signed [9:0] exp_n;
    logic [22:0]       frac;
    logic              any_nan, any_inf, any_zero;
    logic [31:0]       res;

    // Stage 2: normalize the 1.x/1x.x product and apply special-case priority
    always_comb begin
        exp_n = s1_q.prod[15] ? s1_q.exp + 10'sd1 : s1_q.exp;
        frac  = s1_q.prod[15] ? {s1_q.prod[14:0], 8'b0} : {s1_q.prod[13:0], 9'b0};

        any_nan  = (s1_q.cls_a == FP_NAN)  || (s1_q.cls_b == FP_NAN);
        any_inf  = (s1_q.cls_a == FP_INF)  || (s1_q.cls_b == FP_INF);
        any_zero = (s1_q.cls_a == FP_ZERO) || (s1_q.cls_b == FP_ZERO);

        res = {s1_q.sign, exp_n[7:0], frac};
        if (any_nan || (any_inf && any_zero)) res = FP32_QNAN;
        else if (any_inf)                     res = {s1_q.sign, 8'hFF, 23'h0};
        else if (any_zero)                    res = {s1_q.sign, 31'h0};
        else if (exp_n >= 10'sd255)           res = {s1_q.sign, 8'hFF, 23'h0};
        else if (exp_n <= 10'sd0)             res = {s1_q.sign, 31'h0};
    end

    // Output register holds its last product while no new one arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              out <= 32'h0;
        else if (vld_pipe[1]) out <= res;
    end

    assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_bf16_fp32_mul.sv
// Directed + randomized bench for bf16_fp32_mul against an arithmetic model.
module tb_bf16_fp32_mul;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic [31:0] out;

    int n_assert = 0;
    int n_fail   = 0;

    // Expected-output tracking: entry 0 was issued last cycle, entry 1 the cycle before
    logic        pv [2];
    logic [31:0] pd [2];
    string       ptag [2];
    logic [31:0] last_out;

    bf16_fp32_mul #(.FLUSH_DENORM(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(out_valid), .out(out)
    );

    always #5 clk = ~clk;

    // Reference: value = m * 2^(ea+eb-254-14), normalized by locating the MSB of m
    function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
        int  ex, ey, mx, my, m, k, be;
        logic s, nx, ny, ix, iy, zx, zy;
        ex = int'(x[14:7]); mx = int'(x[6:0]);
        ey = int'(y[14:7]); my = int'(y[6:0]);
        s  = x[15] ^ y[15];
        nx = (ex == 255) && (mx != 0);  ny = (ey == 255) && (my != 0);
        ix = (ex == 255) && (mx == 0);  iy = (ey == 255) && (my == 0);
        zx = (ex == 0);                 zy = (ey == 0);
        if (nx || ny || (ix && zy) || (iy && zx)) return 32'h7FC00000;
        if (ix || iy) return {s, 8'hFF, 23'h0};
        if (zx || zy) return {s, 31'h0};
        m = (128 + mx) * (128 + my);
        k = 0;
        while ((m >> (k + 1)) != 0) k++;
        be = ex + ey - 127 - 14 + k;
        if (be >= 255) return {s, 8'hFF, 23'h0};
        if (be <= 0)   return {s, 31'h0};
        return {s, 8'(be), 23'((m - (1 << k)) << (23 - k))};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One cycle: check outputs of earlier edges, then drive this cycle's input
    task automatic step(input logic v, input logic [15:0] ta, input logic [15:0] tbv,
                        input logic [31:0] expv, input string tag);
        @(negedge clk);
        chk({ptag[1], "/valid"}, 32'(out_valid), 32'(pv[1]));
        chk({ptag[1], "/out"}, out, pv[1] ? pd[1] : last_out);
        if (pv[1]) last_out = pd[1];
        pv[1] = pv[0]; pd[1] = pd[0]; ptag[1] = ptag[0];
        in_valid = v; a = ta; b = tbv;
        pv[0] = v; pd[0] = expv; ptag[0] = tag;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 32'h0, "idle");
    endtask

    logic [15:0] ra, rb;

    function automatic logic [15:0] rand_op();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 9))
            0:       r[14:7] = 8'h00;
            1:       r[14:7] = 8'hFF;
            2, 3:    r[14:7] = 8'($urandom_range(180, 254));
            4, 5:    r[14:7] = 8'($urandom_range(1, 70));
            default: r[14:7] = 8'($urandom_range(100, 154));
        endcase
        return r;
    endfunction

    initial begin
        pv[0] = 1'b0; pv[1] = 1'b0; pd[0] = '0; pd[1] = '0;
        ptag[0] = "init"; ptag[1] = "init"; last_out = '0;

        // Reset state
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset/valid", 32'(out_valid), 32'h0);
        chk("reset/out", out, 32'h0);
        rst = 1'b0;

        // Basic products, each isolated
        step(1'b1, 16'h3F80, 16'h3F80, 32'h3F800000, "one_x_one");   idle(3);
        step(1'b1, 16'h3FC0, 16'h3FC0, 32'h40100000, "p15_path");    idle(3);
        step(1'b1, 16'hC000, 16'h4040, 32'hC0C00000, "neg_six");     idle(3);

        // Range limits
        step(1'b1, 16'h7F00, 16'h4000, 32'h7F800000, "overflow");    idle(3);
        step(1'b1, 16'h0080, 16'h3F00, 32'h00000000, "underflow");   idle(3);
        step(1'b1, 16'h8000, 16'h3F80, 32'h80000000, "neg_zero");    idle(3);
        step(1'b1, 16'h0040, 16'h3F80, 32'h00000000, "subnorm_in");  idle(3);

        // Specials
        step(1'b1, 16'h7F80, 16'h0000, 32'h7FC00000, "inf_x_zero");  idle(3);
        step(1'b1, 16'hFF80, 16'h4000, 32'hFF800000, "neg_inf");     idle(3);
        step(1'b1, 16'h7FC1, 16'h3F80, 32'h7FC00000, "nan_in");      idle(3);

        // Streaming, three back-to-back
        step(1'b1, 16'h3F80, 16'h4000, 32'h40000000, "stream0");
        step(1'b1, 16'h4040, 16'h4040, 32'h41100000, "stream1");
        step(1'b1, 16'hBF80, 16'h3F00, 32'hBF000000, "stream2");
        idle(3);

        // Reset with two ops in flight: first result already visible
        step(1'b1, 16'h3F80, 16'h3F80, 32'h3F800000, "pre_rst0");
        step(1'b1, 16'h4000, 16'h4000, 32'h40800000, "pre_rst1");
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst/valid", 32'(out_valid), 32'h0);
        chk("mid_rst/out", out, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        pv[0] = 1'b0; pv[1] = 1'b0; ptag[0] = "post_rst"; ptag[1] = "post_rst";
        last_out = 32'h0;
        idle(4);

        // Randomized traffic with random bubbles
        for (int i = 0; i < 400; i++) begin
            ra = rand_op();
            rb = rand_op();
            step(1'($urandom_range(0, 3) != 0), ra, rb, ref_mul(ra, rb),
                 $sformatf("rnd%0d_%h_%h", i, ra, rb));
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
